// File: rtl/outpkt_checksum_ivl_pkg.sv
// Shared constants for the outgoing-packet checksum inserter:
// FSM state encoding and the MSB() width helper.
package outpkt_checksum_ivl_pkg;

  typedef enum logic [1:0] {
    ST_INPUT = 2'd0,
    ST_PAD   = 2'd1,
    ST_CK_LO = 2'd2,
    ST_CK_HI = 2'd3
  } state_t;

  // Index of the highest set bit; msb(n)+1 bits hold n.
  function automatic int msb(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if (v[i]) r = i;
    return r;
  endfunction

endpackage

// File: rtl/outpkt_cksum_acc.sv
// Segment checksum accumulator: pairs 16-bit words as
// {second, first} and adds them into a wrapping 32-bit sum.
// Ports: CLK, rst; add/start/pad/clr controls, word in;
// pend (half pair held) and sum out.
module outpkt_cksum_acc (
  input  logic        CLK,
  input  logic        rst,
  input  logic        add,
  input  logic        start,
  input  logic        pad,
  input  logic        clr,
  input  logic [15:0] word,
  output logic        pend,
  output logic [31:0] sum
);

  logic [15:0] lo;

  always_ff @(posedge CLK) begin
    if (rst || clr) begin
      pend <= 1'b0;
      lo   <= '0;
      sum  <= '0;
    end else if (add) begin
      // A start word always opens a new pair
      // on a fresh sum, dropping stale state.
      if (pend && !start) begin
        sum  <= sum + {word, lo};
        pend <= 1'b0;
      end else begin
        lo   <= word;
        pend <= 1'b1;
        if (start) sum <= '0;
      end
    end else if (pad) begin
      sum  <= sum + {16'h0000, lo};
      pend <= 1'b0;
    end
  end

endmodule

// File: rtl/outpkt_checksum_ivl.sv
// Outgoing packet checksum inserter: passes header/data words
// and appends a 2-word checksum after the header, after every
// CHECKSUM_INTERVAL data bytes and at packet end.
// Ports: CLK, rst; din/pkt_new/pkt_end/wr_en/full in;
// dout/pkt_end_out/rd_en/empty out (first-word-fall-through).
module outpkt_checksum_ivl #(
  parameter int HEADER_LEN        = 10,
  parameter int CHECKSUM_INTERVAL = 448
) (
  input  logic        CLK,
  input  logic        rst,
  input  logic [15:0] din,
  input  logic        pkt_new,
  input  logic        pkt_end,
  input  logic        wr_en,
  output logic        full,
  output logic [15:0] dout,
  output logic        pkt_end_out,
  input  logic        rd_en,
  output logic        empty
);

  import outpkt_checksum_ivl_pkg::*;

  localparam int HDR_W = HEADER_LEN / 2;
  localparam int IVL_W = CHECKSUM_INTERVAL / 2;
  localparam int CMAX  = (HDR_W > IVL_W) ? HDR_W : IVL_W;
  localparam int CW    = msb(CMAX) + 1;

  state_t state, state_nx;

  logic          in_vld;
  logic [15:0]   in_dat;
  logic          in_new;
  logic          in_end;
  logic          out_vld;
  logic          hdr;
  logic          seg_end;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_eff;

  logic          out_rdy;
  logic          take;
  logic          accept;
  logic          hdr_eff;
  logic          last;
  logic          half;
  logic [31:0]   sum;

  logic          acc_add;
  logic          acc_pad;
  logic          acc_clr;
  logic          out_ld;
  logic [15:0]   out_d;
  logic          out_e;

  assign full    = in_vld | (state != ST_INPUT);
  assign empty   = ~out_vld;
  assign out_rdy = ~out_vld | rd_en;
  assign take    = (state == ST_INPUT) & in_vld & out_rdy;
  assign accept  = wr_en & (~full | take);
  assign hdr_eff = hdr | in_new;
  assign cnt_eff = in_new ? '0 : cnt;

  always_comb begin
    last = 1'b0;
    if (hdr_eff)
      last = (cnt_eff == CW'(HDR_W - 1));
    else if (in_end)
      last = 1'b1;
    else if (IVL_W != 0)
      last = (cnt_eff == CW'(IVL_W - 1));
  end

  outpkt_cksum_acc u_acc (
    .CLK   (CLK),
    .rst   (rst),
    .add   (acc_add),
    .start (in_new),
    .pad   (acc_pad),
    .clr   (acc_clr),
    .word  (in_dat),
    .pend  (half),
    .sum   (sum)
  );

  always_ff @(posedge CLK) begin
    if (rst) state <= ST_INPUT;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    acc_add  = 1'b0;
    acc_pad  = 1'b0;
    acc_clr  = 1'b0;
    out_ld   = 1'b0;
    out_d    = in_dat;
    out_e    = 1'b0;
    unique case (state)
      ST_INPUT: begin
        if (take) begin
          acc_add = 1'b1;
          out_ld  = 1'b1;
          // Odd word count leaves a half pair to pad.
          if (last)
            state_nx = (half && !in_new) ? ST_CK_LO : ST_PAD;
        end
      end
      ST_PAD: begin
        acc_pad  = 1'b1;
        state_nx = ST_CK_LO;
      end
      ST_CK_LO: begin
        if (out_rdy) begin
          out_ld   = 1'b1;
          out_d    = ~sum[15:0];
          state_nx = ST_CK_HI;
        end
      end
      ST_CK_HI: begin
        if (out_rdy) begin
          out_ld   = 1'b1;
          out_d    = ~sum[31:16];
          out_e    = seg_end;
          acc_clr  = 1'b1;
          state_nx = ST_INPUT;
        end
      end
      default: state_nx = ST_INPUT;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      in_vld      <= 1'b0;
      in_dat      <= '0;
      in_new      <= 1'b0;
      in_end      <= 1'b0;
      out_vld     <= 1'b0;
      dout        <= '0;
      pkt_end_out <= 1'b0;
      hdr         <= 1'b1;
      seg_end     <= 1'b0;
      cnt         <= '0;
    end else begin
      if (accept) begin
        in_vld <= 1'b1;
        in_dat <= din;
        in_new <= pkt_new;
        in_end <= pkt_end;
      end else if (take) begin
        in_vld <= 1'b0;
      end

      if (out_ld) begin
        out_vld     <= 1'b1;
        dout        <= out_d;
        pkt_end_out <= out_e;
      end else if (rd_en) begin
        out_vld <= 1'b0;
      end

      if (take) begin
        if (in_new) hdr <= 1'b1;
        if (last)
          cnt <= '0;
        else if (hdr_eff || IVL_W != 0)
          cnt <= cnt_eff + CW'(1);
        else
          cnt <= '0;
        if (last) seg_end <= ~hdr_eff & in_end;
      end

      // Header and packet-end checksums flip the phase;
      // intermediate checksums stay in the data phase.
      if (acc_clr) begin
        cnt     <= '0;
        seg_end <= 1'b0;
        if (hdr || seg_end) hdr <= ~hdr;
      end
    end
  end

endmodule
